// File: rtl/regfile_mp_sb_if.sv
// Decode-side bundle for regfile_mp_sb: writeback port, read ports, reservations and init status.
// The master side is decode/writeback; the slave side is the register file.
interface regfile_mp_sb_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*AW-1:0]     rs_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic                     init_done;

  modport master (
    output wr_en, wr_addr, wr_data, rs_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rs_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, init_done
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with x0 hardwired to zero, write forwarding, a post-reset
// clear sequencer and a per-register busy scoreboard for RAW hazard detection in decode.
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2
) (
  input logic            clk,
  input logic            rst,
  regfile_mp_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  typedef enum logic {StClear, StRun} state_e;

  state_e              state_q;
  logic [AW-1:0]       clr_ptr_q;
  logic                init_done_q;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;

  logic run;
  logic wr_fire;
  logic rsv_fire;

  assign run      = (state_q == StRun);
  assign wr_fire  = run && bus.wr_en && (bus.wr_addr != '0);
  assign rsv_fire = run && bus.rsv_en && (bus.rsv_addr != '0);

  // Clear sequencer: one register per cycle, then hand over to normal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StClear;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == AW'(NUM_REGS - 1)) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
        end
        StRun: begin
          state_q     <= StRun;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= StClear;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the sequencer zeroes it before any read can see it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_fire) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Reservation is applied after the writeback clear so a new producer keeps the bit set.
  always_comb begin
    sb_d = sb_q;
    if (wr_fire) begin
      sb_d[bus.wr_addr] = 1'b0;
    end
    if (rsv_fire) begin
      sb_d[bus.rsv_addr] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      logic [AW-1:0] a;
      logic          fwd;
      a   = bus.rs_addr[i*AW +: AW];
      fwd = bus.wr_en && (bus.wr_addr == a);
      if (run && (a != '0)) begin
        bus.rd_data[i*DATA_W +: DATA_W] = fwd ? bus.wr_data : mem_q[a];
        bus.rd_busy[i]                  = sb_q[a] & ~fwd;
      end
    end
  end

  assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised bench for regfile_mp_sb with an array-based reference model and directed anchors.
module tb_regfile_mp_sb;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned NUM_RD   = 3;
  localparam int unsigned AW       = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) bus ();

  regfile_mp_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents, busy set, and edges elapsed since reset was last seen high.
  logic [31:0] m_mem [NUM_REGS];
  bit          m_sb  [NUM_REGS];
  int          m_cnt   = 0;
  bit          m_valid = 0;

  function automatic bit m_run();
    return m_valid && (m_cnt == int'(NUM_REGS));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_cnt   = 0;
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        m_mem[r] = 0;
        m_sb[r]  = 0;
      end
    end else if (m_valid) begin
      if (m_cnt < int'(NUM_REGS)) begin
        m_cnt++;
      end else begin
        if (bus.wr_en && bus.wr_addr != 0) begin
          m_mem[bus.wr_addr] = bus.wr_data;
          m_sb[bus.wr_addr]  = 0;
        end
        if (bus.rsv_en && bus.rsv_addr != 0) m_sb[bus.rsv_addr] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("init_done", 32'(bus.init_done), 32'(m_run()));
      for (int i = 0; i < int'(NUM_RD); i++) begin
        int          a;
        logic [31:0] ed;
        bit          eb;
        a  = int'(bus.rs_addr[i*AW +: AW]);
        ed = 0;
        eb = 0;
        if (m_run() && a != 0) begin
          if (bus.wr_en && int'(bus.wr_addr) == a) begin
            ed = bus.wr_data;
          end else begin
            ed = m_mem[a];
            eb = m_sb[a];
          end
        end
        chk($sformatf("rd_data[%0d] a=%0d", i, a), bus.rd_data[i*DATA_W +: DATA_W], ed);
        chk($sformatf("rd_busy[%0d] a=%0d", i, a), 32'(bus.rd_busy[i]), 32'(eb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ports(input int a0, input int a1, input int a2);
    bus.rs_addr[0*AW +: AW] = AW'(a0);
    bus.rs_addr[1*AW +: AW] = AW'(a1);
    bus.rs_addr[2*AW +: AW] = AW'(a2);
  endtask

  function automatic logic [31:0] port_data(input int p);
    return bus.rd_data[p*DATA_W +: DATA_W];
  endfunction

  task automatic idle_inputs();
    bus.wr_en    = 0;
    bus.wr_addr  = 0;
    bus.wr_data  = 0;
    bus.rsv_en   = 0;
    bus.rsv_addr = 0;
  endtask

  task automatic write(input int a, input logic [31:0] d);
    bus.wr_en   = 1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
  endtask

  // Counts edges until init_done; optionally pokes a write+reserve of x4 at a given clear cycle.
  task automatic wait_init(input int poke_at);
    int n;
    n = 0;
    while (bus.init_done !== 1'b1 && n < 100) begin
      if (n == poke_at) begin
        write(4, 32'hFF);
        bus.rsv_en   = 1;
        bus.rsv_addr = 4;
      end
      tick();
      idle_inputs();
      n++;
    end
    chk("init_latency", 32'(n), 32'd32);
  endtask

  initial begin
    idle_inputs();
    set_ports(0, 0, 0);

    rst = 1;
    tick();
    tick();
    chk("init_in_reset", 32'(bus.init_done), 32'd0);
    rst = 0;
    wait_init(-1);

    for (int r = 0; r < int'(NUM_REGS); r += 3) begin
      set_ports(r, (r + 1) % NUM_REGS, (r + 2) % NUM_REGS);
      #1;
      for (int p = 0; p < 3; p++) chk($sformatf("cleared p%0d", p), port_data(p), 32'h0);
    end

    // Reset again mid-clear; a write+reserve during the restarted clear must be dropped.
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1;
    tick();
    rst = 0;
    wait_init(3);
    set_ports(4, 0, 0);
    #1;
    chk("x4 after clear", port_data(0), 32'h0);
    chk("x4 busy after clear", 32'(bus.rd_busy[0]), 32'd0);

    write(5, 32'hDEADBEEF);
    tick();
    write(0, 32'h12345678);
    tick();
    idle_inputs();
    set_ports(5, 0, 5);
    #1;
    chk("x5 p0", port_data(0), 32'hDEADBEEF);
    chk("x0 p1", port_data(1), 32'h0);
    chk("x5 p2", port_data(2), 32'hDEADBEEF);

    write(7, 32'h77);
    tick();
    write(6, 32'hCAFEBABE);
    set_ports(6, 6, 7);
    #1;
    chk("fwd p0", port_data(0), 32'hCAFEBABE);
    chk("fwd p1", port_data(1), 32'hCAFEBABE);
    chk("old x7 p2", port_data(2), 32'h77);
    tick();
    idle_inputs();
    #1;
    chk("x6 stored", port_data(0), 32'hCAFEBABE);

    bus.rsv_en   = 1;
    bus.rsv_addr = 9;
    set_ports(9, 0, 0);
    #1;
    chk("rsv not yet visible", 32'(bus.rd_busy[0]), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("x9 busy", 32'(bus.rd_busy[0]), 32'd1);
    tick();
    tick();
    write(9, 32'h55);
    #1;
    chk("x9 wb busy", 32'(bus.rd_busy[0]), 32'd0);
    chk("x9 wb data", port_data(0), 32'h55);
    tick();
    idle_inputs();
    #1;
    chk("x9 busy after", 32'(bus.rd_busy[0]), 32'd0);
    chk("x9 data after", port_data(0), 32'h55);

    bus.rsv_en   = 1;
    bus.rsv_addr = 3;
    tick();
    write(3, 32'hA5);
    tick();
    idle_inputs();
    set_ports(3, 0, 0);
    #1;
    chk("x3 rsv+wb data", port_data(0), 32'hA5);
    chk("x3 rsv+wb busy", 32'(bus.rd_busy[0]), 32'd1);
    bus.rsv_en   = 1;
    bus.rsv_addr = 0;
    tick();
    idle_inputs();
    set_ports(0, 3, 0);
    #1;
    chk("x0 busy", 32'(bus.rd_busy[0]), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      bit narrow;
      narrow       = ($urandom_range(0, 1) == 1);
      rst          = ($urandom_range(0, 399) == 0);
      bus.wr_en    = ($urandom_range(0, 2) != 0);
      bus.wr_addr  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      bus.wr_data  = $urandom;
      bus.rsv_en   = ($urandom_range(0, 2) == 0);
      bus.rsv_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      for (int p = 0; p < int'(NUM_RD); p++) begin
        bus.rs_addr[p*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      end
      tick();
    end
    rst = 0;
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised successor to the decode-stage register file.
- Adds a configurable number of combinational read ports, same-cycle write forwarding on every port, and x0 hardwired to zero.
- Clears itself with a hardware sequencer after reset, replacing hex-file initialisation.
- Integrates a per-register busy scoreboard so decode can detect RAW hazards against in-flight producers.
- Sits in decode between the instruction decoder (read addresses, reservations) and writeback (write port).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers; power of two, >= 2
NUM_RD, 2, number of read ports (>= 1)
AW, $clog2(NUM_REGS), address width (derived; not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  writeback write enable
wr_addr  in  AW  writeback destination register
wr_data  in  DATA_W  writeback data
rs_addr  in  NUM_RD*AW  packed read addresses; port i = bits [i*AW +: AW]
rd_data  out  NUM_RD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  per-port busy flag, 1 = operand not yet valid
rsv_en  in  1  reserve destination (instruction issued with a register write)
rsv_addr  in  AW  register to mark busy
init_done  out  1  1 = clear sequence finished, block accepts writes and reservations

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Two-state FSM, CLEAR and RUN.
  - rst=1 at an edge: state<=CLEAR, clr_ptr<=0, all scoreboard bits<=0. Applies in any state, including mid-CLEAR, which restarts from pointer 0.
  - CLEAR: every cycle mem[clr_ptr]<=0 and clr_ptr<=clr_ptr+1. When clr_ptr==NUM_REGS-1, state<=RUN.
  - The first RUN cycle is exactly NUM_REGS edges after the edge at which rst was last sampled high.
- init_done: registered; equals (state==RUN). Reset value is 0.
- During CLEAR:
  - wr_en and rsv_en are ignored.
  - All rd_data = 0 and all rd_busy = 0.
- Writes (RUN only): at the edge, if wr_en && wr_addr!=0, then mem[wr_addr]<=wr_data. Writes to address 0 are discarded.
- Reads are combinational, with zero-cycle latency, per port i with address a = rs_addr[i]:
  - a==0 → rd_data=0.
  - else if wr_en && wr_addr==a (RUN) → rd_data=wr_data (forwarding).
  - else → rd_data=mem[a].
- Scoreboard: sb[NUM_REGS-1:1]; sb[0] is constant 0. Next-state per register r!=0, in RUN:
  - rsv_en && rsv_addr==r → set.
  - else if wr_en && wr_addr==r → clear.
  - else hold.
  - Reservation and writeback to the same register in the same cycle leave the bit set: the new producer wins, and the data write still occurs.
  - rsv_addr==0 has no effect.
- rd_busy[i]:
  - Equals sb[a] & ~(wr_en && wr_addr==a); the forwarded writeback makes the operand valid this cycle.
  - A reservation issued this cycle is not visible until the next cycle.
  - a==0 → 0.
- Multiple read ports addressing the same register return identical values; there is no port-priority effect.
- A write to an unreserved register is legal: data is written and the scoreboard is unchanged.
- Out-of-range addresses are impossible by construction (NUM_REGS is a power of two).
- Outputs during and immediately after rst: rd_data=0, rd_busy=0, init_done=0.

Test Plan (DATA_W=32, NUM_REGS=32, NUM_RD=3):
1. Reset and clear:
   - Stimulus: rst high 2 cycles, then low.
   - Required: init_done=0 for 32 cycles, 1 on the 32nd edge after rst low. All 32 registers read back 0.
   - Repeat with rst pulsed at clear cycle 10: init_done is delayed a further 32 edges from the new pulse.
2. Write/read and x0:
   - Stimulus: write x5=0xDEADBEEF, x0=0x12345678. Next cycle, ports = {5,0,5}.
   - Required: rd_data = {0xDEADBEEF, 0, 0xDEADBEEF}.
3. Forwarding:
   - Stimulus: wr_en=1, wr_addr=6, wr_data=0xCAFEBABE; rs_addr={6,6,7}, all in the same cycle, before the edge.
   - Required: ports 0 and 1 = 0xCAFEBABE; port 2 = old x7.
4. Scoreboard:
   - Stimulus: rsv x9. Next cycle, read port0=9.
   - Required: rd_busy[0]=1.
   - Stimulus: later, write x9=0x55 with port0=9.
   - Required: rd_busy[0]=0 and rd_data=0x55 in the same cycle; the next cycle, busy stays 0.
5. Simultaneous reserve and writeback:
   - Stimulus: sb[3]=1; rsv x3 and write x3=0xA5 in the same cycle.
   - Required: the next cycle reads x3=0xA5 with busy=1.
   - Also: rsv x0 → busy for x0 stays 0.
6. Ignore during CLEAR:
   - Stimulus: assert wr_en (x4=0xFF) and rsv x4 at clear cycle 3.
   - Required: after init_done, x4 reads 0 and busy=0.
